// File: rtl/rf_safe_shutdown_if.sv
// rf_safe_shutdown_if: control inputs and gated amplitude outputs of the RF safe-shutdown block.
interface rf_safe_shutdown_if #(parameter int AW = 16);
    logic          force_reset;
    logic          arm;
    logic          stop;
    logic          clear_fault;
    logic [AW-1:0] amp_in;
    logic [AW-1:0] amp_out;
    logic          rf_enable;
    logic          fault_latched;
    logic [2:0]    state;
    modport master (output force_reset, arm, stop, clear_fault, amp_in,
                    input amp_out, rf_enable, fault_latched, state);
    modport slave (input force_reset, arm, stop, clear_fault, amp_in,
                   output amp_out, rf_enable, fault_latched, state);
endinterface

// File: rtl/rf_safe_shutdown.sv
// rf_safe_shutdown: ramps carrier amplitude up/down, latches watchdog faults and enforces a post-fault lockout.
module rf_safe_shutdown #(
    parameter int AW       = 16,
    parameter int STEP     = 256,
    parameter int STEP_DIV = 4,
    parameter int LOCKOUT  = 1000
) (
    input logic           clk,
    input logic           rst,
    rf_safe_shutdown_if.slave bus
);
    localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int LW = LOCKOUT > 1 ? $clog2(LOCKOUT) : 1;
    typedef enum logic [2:0] {
        S_MUTED     = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_ACTIVE    = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_LOCK      = 3'd4
    } state_t;
    state_t        st, nxt;
    logic [AW-1:0] amp, amp_d, amp_up, amp_dn;
    logic [AW:0]   sum;
    logic [DW-1:0] div;
    logic [LW-1:0] lock, lock_d;
    logic          fault, fault_d, tick;
    assign tick   = div == DW'(STEP_DIV - 1);
    // one extra bit so a ramp near full scale saturates at amp_in instead of wrapping
    assign sum    = {1'b0, amp} + (AW+1)'(STEP);
    assign amp_up = (sum > {1'b0, bus.amp_in}) ? bus.amp_in : sum[AW-1:0];
    assign amp_dn = (amp > AW'(STEP)) ? amp - AW'(STEP) : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= S_MUTED;
            amp   <= '0;
            fault <= 1'b0;
            lock  <= '0;
            div   <= '0;
        end else begin
            st    <= nxt;
            amp   <= amp_d;
            fault <= fault_d;
            lock  <= lock_d;
            div   <= (nxt != st || tick) ? '0 : div + DW'(1);
        end
    end
    always_comb begin
        nxt     = st;
        amp_d   = amp;
        fault_d = fault;
        lock_d  = lock;
        case (st)
            S_MUTED: begin
                amp_d = '0;
                if (bus.force_reset) fault_d = 1'b1;
                else if (bus.clear_fault) fault_d = 1'b0;
                else if (bus.arm && !fault) nxt = S_RAMP_UP;
            end
            S_RAMP_UP, S_ACTIVE: begin
                amp_d = (st == S_ACTIVE) ? bus.amp_in : (tick ? amp_up : amp);
                if (bus.force_reset) begin
                    fault_d = 1'b1;
                    nxt     = S_RAMP_DOWN;
                end else if (bus.stop) nxt = S_RAMP_DOWN;
                else if (st == S_RAMP_UP && amp == bus.amp_in) nxt = S_ACTIVE;
            end
            S_RAMP_DOWN: begin
                amp_d = tick ? amp_dn : amp;
                if (bus.force_reset) fault_d = 1'b1;
                if (amp == '0) begin
                    nxt    = (fault || bus.force_reset) ? S_LOCK : S_MUTED;
                    lock_d = LW'(LOCKOUT - 1);
                end
            end
            S_LOCK: begin
                amp_d = '0;
                if (bus.force_reset) lock_d = LW'(LOCKOUT - 1);
                else if (lock == '0) nxt = S_MUTED;
                else lock_d = lock - LW'(1);
            end
            default: nxt = S_MUTED;
        endcase
    end
    assign bus.amp_out       = amp;
    assign bus.fault_latched = fault;
    assign bus.state         = st;
    assign bus.rf_enable     = st == S_RAMP_UP || st == S_ACTIVE || st == S_RAMP_DOWN;
endmodule

// File: tb/tb_rf_safe_shutdown.sv
// tb_rf_safe_shutdown: randomized and directed stimulus against a cycle-level behavioural model.
module tb_rf_safe_shutdown;
    localparam int AW = 16, STEP = 256, SD = 4, LK = 8;
    logic clk = 0, rst = 1;
    int   n_chk = 0, n_fail = 0;
    rf_safe_shutdown_if #(.AW(AW)) bus ();
    rf_safe_shutdown #(.AW(AW), .STEP(STEP), .STEP_DIV(SD), .LOCKOUT(LK)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    // model: state numbering from the block's public state output, time measured as cycles since entry
    int m_st, m_amp, m_age, m_left;
    bit m_fault;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_st = 0; m_amp = 0; m_age = 0; m_left = 0; m_fault = 0;
    endtask
    task automatic model_step();
        int  ns, na, nl, ain;
        bit  nf, f, tick;
        ain  = int'(bus.amp_in);
        f    = bus.force_reset;
        tick = (m_age % SD) == SD - 1;
        ns = m_st; na = m_amp; nf = m_fault; nl = m_left;
        if (m_st == 0) begin
            na = 0;
            if (f) nf = 1;
            else if (bus.clear_fault) nf = 0;
            else if (bus.arm && !m_fault) ns = 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (m_st == 2) na = ain;
            else if (tick) na = (m_amp + STEP < ain) ? m_amp + STEP : ain;
            if (f) begin nf = 1; ns = 3; end
            else if (bus.stop) ns = 3;
            else if (m_st == 1 && m_amp == ain) ns = 2;
        end else if (m_st == 3) begin
            if (tick) na = (m_amp > STEP) ? m_amp - STEP : 0;
            if (f) nf = 1;
            if (m_amp == 0) begin ns = (m_fault || f) ? 4 : 0; nl = LK - 1; end
        end else begin
            na = 0;
            if (f) nl = LK - 1;
            else if (m_left == 0) ns = 0;
            else nl = m_left - 1;
        end
        m_age = (ns != m_st) ? 0 : m_age + 1;
        m_st = ns; m_amp = na; m_fault = nf; m_left = nl;
    endtask
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("amp_out", int'(bus.amp_out), m_amp);
        check("state", int'(bus.state), m_st);
        check("rf_enable", int'(bus.rf_enable), int'(m_st >= 1 && m_st <= 3));
        check("fault_latched", int'(bus.fault_latched), int'(m_fault));
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic pulse_arm();
        bus.arm = 1; step(); bus.arm = 0;
    endtask
    initial begin
        bus.force_reset = 0; bus.arm = 0; bus.stop = 0; bus.clear_fault = 0; bus.amp_in = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_amp", int'(bus.amp_out), 0);
        check("rst_state", int'(bus.state), 0);
        check("rst_rf", int'(bus.rf_enable), 0);
        check("rst_fault", int'(bus.fault_latched), 0);
        rst = 0;
        // ramp up to 1024
        bus.amp_in = 1024;
        pulse_arm();
        run(4);
        check("t1_first_step", int'(bus.amp_out), 256);
        run(12);
        check("t1_reach", int'(bus.amp_out), 1024);
        check("t1_still_ramp", int'(bus.state), 1);
        run(1);
        check("t1_active", int'(bus.state), 2);
        // fault ramp-down into lockout
        bus.force_reset = 1; step(); bus.force_reset = 0;
        check("t2_fault", int'(bus.fault_latched), 1);
        run(17);
        check("t2_lockout", int'(bus.state), 4);
        run(8);
        check("t2_muted", int'(bus.state), 0);
        check("t2_rf_off", int'(bus.rf_enable), 0);
        // latched fault blocks arm until cleared
        pulse_arm(); run(3);
        check("t3_blocked", int'(bus.state), 0);
        bus.clear_fault = 1; bus.arm = 1; step(); bus.clear_fault = 0;
        check("t3_clear_prio", int'(bus.state), 0);
        step(); bus.arm = 0;
        check("t3_rearm", int'(bus.state), 1);
        run(20);
        // graceful stop from 1000
        bus.amp_in = 1000; run(2);
        bus.stop = 1; step(); bus.stop = 0;
        run(4);
        check("t4_first_down", int'(bus.amp_out), 744);
        run(20);
        check("t4_muted", int'(bus.state), 0);
        check("t4_no_fault", int'(bus.fault_latched), 0);
        bus.arm = 1; bus.force_reset = 1; step(); bus.arm = 0; bus.force_reset = 0;
        check("t3_arm_force", int'(bus.state), 0);
        bus.clear_fault = 1; step(); bus.clear_fault = 0;
        pulse_arm(); run(25);
        bus.stop = 1; bus.force_reset = 1; step(); bus.stop = 0; bus.force_reset = 0;
        run(40);
        check("t4_fault_wins", int'(bus.fault_latched), 1);
        bus.clear_fault = 1; step(); bus.clear_fault = 0;
        // full-scale ramp saturates without wrap
        bus.amp_in = 16'hFFFF;
        pulse_arm(); run(1040);
        check("t5_full", int'(bus.amp_out), 65535);
        bus.stop = 1; step(); bus.stop = 0;
        run(1040);
        // target lowered mid-ramp
        bus.amp_in = 1024;
        pulse_arm(); run(8);
        check("t5_mid", int'(bus.amp_out), 512);
        bus.amp_in = 300; run(4);
        check("t5_clamp", int'(bus.amp_out), 300);
        run(1);
        check("t5_active", int'(bus.state), 2);
        // asynchronous reset mid ramp-down
        bus.force_reset = 1; step(); bus.force_reset = 0;
        run(5);
        #3 rst = 1;
        #1;
        check("t6_amp", int'(bus.amp_out), 0);
        check("t6_rf", int'(bus.rf_enable), 0);
        check("t6_fault", int'(bus.fault_latched), 0);
        check("t6_state", int'(bus.state), 0);
        model_reset();
        @(posedge clk); #2 rst = 0;
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.force_reset = $urandom_range(0, 59) == 0;
            bus.arm         = $urandom_range(0, 3) == 0;
            bus.stop        = $urandom_range(0, 39) == 0;
            bus.clear_fault = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 49) == 0)
                case ($urandom_range(0, 3))
                    0: bus.amp_in = 16'hFFFF;
                    1: bus.amp_in = 16'($urandom_range(0, 1200));
                    2: bus.amp_in = 16'($urandom_range(0, 65535));
                    default: bus.amp_in = 16'($urandom_range(0, 300));
                endcase
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
